// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor: ALIGN, ADD, iterative NORM.
// Truncating rounding, denormals flushed to zero, one operation in flight.
module fp_add_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   op_a,
    input  logic [EXP_W+MAN_W:0]   op_b,
    input  logic                   op_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   busy
);

    localparam int unsigned MW = MAN_W + 2;
    localparam int unsigned SB = EXP_W + MAN_W;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StAlign = 3'd1;
    localparam logic [2:0] StAdd   = 3'd2;
    localparam logic [2:0] StNorm  = 3'd3;
    localparam logic [2:0] StOut   = 3'd4;

    localparam logic [EXP_W-1:0] ExpMax  = '1;
    localparam logic [EXP_W:0]   ExpMaxW = {1'b0, ExpMax};
    localparam logic [EXP_W:0]   ExpOne  = 1;
    localparam logic [EXP_W:0]   ShMax   = (EXP_W+1)'(MAN_W + 1);
    localparam logic [SB:0]      QNaN    = {1'b0, ExpMax, 1'b1, {(MAN_W-1){1'b0}}};

    logic [2:0]       state_q, state_d;
    logic             sa_q, sa_d, sb_q, sb_d, sr_q, sr_d;
    logic [EXP_W:0]   ea_q, ea_d, eb_q, eb_d, er_q, er_d;
    logic [MW-1:0]    ma_q, ma_d, mb_q, mb_d, mr_q, mr_d;
    logic [SB:0]      res_q, res_d;
    logic             ov_q, ov_d;

    // Operand decode for the accept cycle
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_sgn, b_sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [SB:0]      b_val;

    always_comb begin
        a_sgn  = op_a[SB];
        a_exp  = op_a[MAN_W +: EXP_W];
        a_frac = op_a[MAN_W-1:0];
        b_sgn  = op_b[SB] ^ op_sub;
        b_exp  = op_b[MAN_W +: EXP_W];
        b_frac = op_b[MAN_W-1:0];
        a_zero = (a_exp == '0);
        b_zero = (b_exp == '0);
        a_inf  = (a_exp == ExpMax) && (a_frac == '0);
        b_inf  = (b_exp == ExpMax) && (b_frac == '0);
        a_nan  = (a_exp == ExpMax) && (a_frac != '0);
        b_nan  = (b_exp == ExpMax) && (b_frac != '0);
        b_val  = {b_sgn, op_b[SB-1:0]};
    end

    logic             special;
    logic [SB:0]      spec_res;
    logic [EXP_W:0]   diff, e_inc, e_dec;
    logic [MW-1:0]    shifted;

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sr_d     = sr_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        er_d     = er_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        mr_d     = mr_q;
        res_d    = res_q;
        ov_d     = ov_q;
        special  = 1'b1;
        spec_res = '0;
        diff     = '0;
        e_inc    = er_q + ExpOne;
        e_dec    = er_q - ExpOne;
        shifted  = mr_q << 1;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sa_d = a_sgn;
                    sb_d = b_sgn;
                    ea_d = {1'b0, a_exp};
                    eb_d = {1'b0, b_exp};
                    ma_d = {2'b01, a_frac};
                    mb_d = {2'b01, b_frac};
                    if (a_nan || b_nan || (a_inf && b_inf && (a_sgn != b_sgn))) begin
                        spec_res = QNaN;
                    end else if (a_inf) begin
                        spec_res = op_a;
                    end else if (b_inf) begin
                        spec_res = b_val;
                    end else if (a_zero && b_zero) begin
                        spec_res = {a_sgn & b_sgn, {SB{1'b0}}};
                    end else if (a_zero) begin
                        spec_res = b_val;
                    end else if (b_zero) begin
                        spec_res = op_a;
                    end else begin
                        special = 1'b0;
                    end
                    if (special) begin
                        res_d   = spec_res;
                        ov_d    = 1'b1;
                        state_d = StOut;
                    end else begin
                        state_d = StAlign;
                    end
                end
            end
            StAlign: begin
                if (ea_q >= eb_q) begin
                    diff = ea_q - eb_q;
                    er_d = ea_q;
                    mb_d = (diff > ShMax) ? '0 : (mb_q >> diff);
                end else begin
                    diff = eb_q - ea_q;
                    er_d = eb_q;
                    ma_d = (diff > ShMax) ? '0 : (ma_q >> diff);
                end
                state_d = StAdd;
            end
            StAdd: begin
                state_d = StNorm;
                if (sa_q == sb_q) begin
                    mr_d = ma_q + mb_q;
                    sr_d = sa_q;
                end else if (ma_q > mb_q) begin
                    mr_d = ma_q - mb_q;
                    sr_d = sa_q;
                end else if (mb_q > ma_q) begin
                    mr_d = mb_q - ma_q;
                    sr_d = sb_q;
                end else begin
                    res_d   = '0;
                    ov_d    = 1'b1;
                    state_d = StOut;
                end
            end
            StNorm: begin
                if (mr_q[MW-1]) begin
                    res_d   = (e_inc >= ExpMaxW) ? {sr_q, ExpMax, {MAN_W{1'b0}}}
                                                 : {sr_q, e_inc[EXP_W-1:0], mr_q[MAN_W:1]};
                    ov_d    = 1'b1;
                    state_d = StOut;
                end else if (mr_q[MAN_W]) begin
                    res_d   = {sr_q, er_q[EXP_W-1:0], mr_q[MAN_W-1:0]};
                    ov_d    = 1'b1;
                    state_d = StOut;
                end else if (e_dec == '0) begin
                    res_d   = {sr_q, {SB{1'b0}}};
                    ov_d    = 1'b1;
                    state_d = StOut;
                end else if (shifted[MAN_W]) begin
                    // The shift that sets the hidden bit also packs the result
                    res_d   = {sr_q, e_dec[EXP_W-1:0], shifted[MAN_W-1:0]};
                    ov_d    = 1'b1;
                    state_d = StOut;
                end else begin
                    mr_d = shifted;
                    er_d = e_dec;
                end
            end
            StOut: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            sr_q    <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            er_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            mr_q    <= '0;
            res_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            er_q    <= er_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            mr_q    <= mr_d;
            res_q   <= res_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = ov_q;
    assign result    = res_q;

endmodule
